register_file_mp: RTL

//  Multi-port integer register file for the pipelined RISC-V core.

---
 rtl/core_pkg.sv | 7 +
 rtl/rf_pkg.sv | 12 +
 rtl/rf_scoreboard.sv | 55 +++++
 rtl/register_file_mp.sv | 113 +++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Core-wide shared definitions.
// Widths common to every pipeline stage of the integer core.
package core_pkg;

    localparam int XLEN = 32;

endpackage

// File: rtl/rf_pkg.sv
// Register file local types and constants.
// Shared by the storage/FSM top and the busy scoreboard.
package rf_pkg;

    typedef enum logic {
        RF_INIT,
        RF_RUN
    } rf_state_e;

    localparam int ZERO_REG_ADDR = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on issue, cleared by writeback.
// Issue beats writeback to the same register since the new producer is pending.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int REG_DEPTH = 32,
    parameter int NUM_WR    = 1,
    parameter int NUM_RD    = 2,
    localparam int AW       = $clog2(REG_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic                 iss_en_i,
    input  logic [AW-1:0]        iss_addr_i,
    input  logic [NUM_WR-1:0]    wr_en_i,
    input  logic [NUM_WR*AW-1:0] wr_addr_i,
    input  logic [NUM_RD*AW-1:0] rd_addr_i,
    output logic [NUM_RD-1:0]    busy_o
);

    logic [REG_DEPTH-1:0] busy_q;
    logic [REG_DEPTH-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (en_i) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en_i[j]) begin
                    busy_d[wr_addr_i[j*AW +: AW]] = 1'b0;
                end
            end
            if (iss_en_i) begin
                busy_d[iss_addr_i] = 1'b1;
            end
        end
        busy_d[ZERO_REG_ADDR] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        busy_o = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            busy_o[i] = busy_q[rd_addr_i[i*AW +: AW]];
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with write bypass and busy scoreboard.
// A post-reset sweep zeroes the array one entry per cycle so it maps to RAM.
module register_file_mp
    import rf_pkg::*;
#(
    parameter int XLEN      = core_pkg::XLEN,
    parameter int REG_DEPTH = 32,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 1,
    parameter int BYPASS    = 1,
    localparam int AW       = $clog2(REG_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*XLEN-1:0]   rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*XLEN-1:0]   wr_data,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr,
    output logic                     init_done
);

    localparam logic [AW-1:0] ZA   = AW'(ZERO_REG_ADDR);
    localparam logic [AW-1:0] LAST = AW'(REG_DEPTH - 1);

    rf_state_e         state_q;
    logic [AW-1:0]     sweep_ptr_q;
    logic              init_done_q;
    logic [XLEN-1:0]   regs_q [REG_DEPTH];
    logic [NUM_RD-1:0] sb_busy;
    logic              run;

    assign run       = (state_q == RF_RUN);
    assign init_done = init_done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RF_INIT;
            sweep_ptr_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                RF_INIT: begin
                    sweep_ptr_q <= sweep_ptr_q + AW'(1);
                    if (sweep_ptr_q == LAST) begin
                        state_q     <= RF_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                RF_RUN: begin
                    state_q     <= RF_RUN;
                    init_done_q <= 1'b1;
                end
            endcase
        end
    end

    // No reset on the array: the sweep clears it, keeping it RAM-mappable.
    // Later ports are assigned last, so the highest index wins a conflict.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == RF_INIT) begin
                regs_q[sweep_ptr_q] <= '0;
            end else begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en[j] && (wr_addr[j*AW +: AW] != ZA)) begin
                        regs_q[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    rf_scoreboard #(
        .REG_DEPTH (REG_DEPTH),
        .NUM_WR    (NUM_WR),
        .NUM_RD    (NUM_RD)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (run),
        .iss_en_i   (iss_en),
        .iss_addr_i (iss_addr),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .rd_addr_i  (rd_addr),
        .busy_o     (sb_busy)
    );

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (run && (rd_addr[i*AW +: AW] != ZA)) begin
                rd_data[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
                rd_busy[i]              = sb_busy[i];
                if (BYPASS != 0) begin
                    for (int j = 0; j < NUM_WR; j++) begin
                        if (wr_en[j] &&
                            (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
                            rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                            rd_busy[i]              = 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule
